// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, R-type function fields, ALUOp encodings
// and the controller state encoding.
package alu_pkg;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned CNT_W   = 16;

    localparam logic [SEL_W-1:0] SEL_AND = 4'd0;
    localparam logic [SEL_W-1:0] SEL_OR  = 4'd1;
    localparam logic [SEL_W-1:0] SEL_ADD = 4'd2;
    localparam logic [SEL_W-1:0] SEL_SUB = 4'd6;
    localparam logic [SEL_W-1:0] SEL_SLT = 4'd7;
    localparam logic [SEL_W-1:0] SEL_NOR = 4'd12;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'h27;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/Funct to ALU select decode; shared with the main control unit.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    output logic [SEL_W-1:0]   Sel,
    output logic               Illegal
);

    always_comb begin
        Sel     = SEL_ADD;
        Illegal = 1'b0;
        case (ALUOp)
            ALUOP_ADD: Sel = SEL_ADD;
            ALUOP_SUB: Sel = SEL_SUB;
            ALUOP_RTYPE: begin
                case (Funct)
                    FUNCT_ADD: Sel = SEL_ADD;
                    FUNCT_SUB: Sel = SEL_SUB;
                    FUNCT_AND: Sel = SEL_AND;
                    FUNCT_OR:  Sel = SEL_OR;
                    FUNCT_NOR: Sel = SEL_NOR;
                    FUNCT_SLT: Sel = SEL_SLT;
                    default:   Illegal = 1'b1;
                endcase
            end
            ALUOP_ILL: Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_controller.sv
// Start/ready sequencer in front of the combinational ALU: latches operands and
// select, then registers the ALU result with a one-cycle Done strobe.
module alu_controller
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Ready,
    output logic               Done,
    output logic               Invalid,
    output logic [WIDTH-1:0]   Resultado,
    output logic               ZF,
    output logic [CNT_W-1:0]   OpCount,
    output logic [WIDTH-1:0]   OP1,
    output logic [WIDTH-1:0]   OP2,
    output logic [SEL_W-1:0]   Sel,
    input  logic [WIDTH-1:0]   AluRes,
    input  logic               AluZF
);

    logic [SEL_W-1:0] dec_sel;
    logic             dec_illegal;

    alu_decoder u_dec (
        .ALUOp   (ALUOp),
        .Funct   (Funct),
        .Sel     (dec_sel),
        .Illegal (dec_illegal)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zf_q, zf_d, done_q, done_d, inv_q, inv_d;

    // Next state plus next value of every registered output
    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sel_d   = sel_q;
        res_d   = res_q;
        zf_d    = zf_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        inv_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (dec_illegal) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        inv_d   = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        op1_d   = A;
                        op2_d   = B;
                        sel_d   = dec_sel;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                res_d   = AluRes;
                zf_d    = AluZF;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= SEL_ADD;
            res_q   <= '0;
            zf_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
        end
    end

    assign Ready     = (state_q == ST_IDLE);
    assign Done      = done_q;
    assign Invalid   = inv_q;
    assign Resultado = res_q;
    assign ZF        = zf_q;
    assign OpCount   = cnt_q;
    assign OP1       = op1_q;
    assign OP2       = op2_q;
    assign Sel       = sel_q;

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller with a behavioural ALU and a
// request-level reference model.
module tb_alu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic [31:0] A, B;
    logic        Ready, Done, Invalid, ZF;
    logic [31:0] Resultado, OP1, OP2, AluRes;
    logic [15:0] OpCount;
    logic [3:0]  Sel;
    logic        AluZF;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_res, exp_op1, exp_op2;
    logic        exp_zf;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_sel;

    alu_controller #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .ALUOp     (ALUOp),
        .Funct     (Funct),
        .A         (A),
        .B         (B),
        .Ready     (Ready),
        .Done      (Done),
        .Invalid   (Invalid),
        .Resultado (Resultado),
        .ZF        (ZF),
        .OpCount   (OpCount),
        .OP1       (OP1),
        .OP2       (OP2),
        .Sel       (Sel),
        .AluRes    (AluRes),
        .AluZF     (AluZF)
    );

    always #5 clk = ~clk;

    // The ALU the parent would instantiate
    always_comb begin
        case (Sel)
            4'd0:    AluRes = OP1 & OP2;
            4'd1:    AluRes = OP1 | OP2;
            4'd2:    AluRes = OP1 + OP2;
            4'd6:    AluRes = OP1 - OP2;
            4'd7:    AluRes = ($signed(OP1) < $signed(OP2)) ? 32'd1 : 32'd0;
            4'd12:   AluRes = ~(OP1 | OP2);
            default: AluRes = 32'd0;
        endcase
    end
    assign AluZF = (AluRes == 32'd0);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Request-level reference: legality, select code and result per operation name
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, output logic legal, output logic [3:0] sel,
                         output logic [31:0] r);
        legal = 1'b1;
        sel   = 4'd2;
        r     = a + b;
        if (op == 2'b01) begin
            sel = 4'd6; r = a - b;
        end else if (op == 2'b11) begin
            legal = 1'b0;
        end else if (op == 2'b10) begin
            case (fn)
                6'h20: begin sel = 4'd2;  r = a + b; end
                6'h22: begin sel = 4'd6;  r = a - b; end
                6'h24: begin sel = 4'd0;  r = a & b; end
                6'h25: begin sel = 4'd1;  r = a | b; end
                6'h27: begin sel = 4'd12; r = ~(a | b); end
                6'h2A: begin sel = 4'd7;  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                default: legal = 1'b0;
            endcase
        end
    endtask

    // Called #1 after an edge while idle; returns #1 after the edge that re-enters idle
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b);
        logic        legal;
        logic [3:0]  sel;
        logic [31:0] r;
        model(op, fn, a, b, legal, sel, r);
        chk("ready_before", 64'(Ready), 64'd1);
        Start = 1'b1; ALUOp = op; Funct = fn; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0; A = $urandom; B = $urandom;
        ALUOp = 2'($urandom_range(0, 3)); Funct = 6'($urandom_range(0, 63));
        if (legal) begin
            chk("exec_sel", 64'(Sel), 64'(sel));
            chk("exec_op1", 64'(OP1), 64'(a));
            chk("exec_op2", 64'(OP2), 64'(b));
            chk("exec_ready", 64'(Ready), 64'd0);
            chk("exec_done", 64'(Done), 64'd0);
            exp_sel = sel; exp_op1 = a; exp_op2 = b;
            exp_res = r; exp_zf = (r == 32'd0);
            @(posedge clk); #1;
            chk("done_strobe", 64'(Done), 64'd1);
            chk("done_invalid", 64'(Invalid), 64'd0);
            chk("done_result", 64'(Resultado), 64'(exp_res));
            chk("done_zf", 64'(ZF), 64'(exp_zf));
            chk("done_cnt", 64'(OpCount), 64'(exp_cnt));
            chk("done_ready", 64'(Ready), 64'd0);
            @(posedge clk); #1;
            exp_cnt = exp_cnt + 16'd1;
            chk("after_done", 64'(Done), 64'd0);
            chk("after_ready", 64'(Ready), 64'd1);
            chk("after_cnt", 64'(OpCount), 64'(exp_cnt));
        end else begin
            chk("err_done", 64'(Done), 64'd1);
            chk("err_invalid", 64'(Invalid), 64'd1);
            chk("err_ready", 64'(Ready), 64'd0);
            chk("err_result", 64'(Resultado), 64'(exp_res));
            chk("err_zf", 64'(ZF), 64'(exp_zf));
            chk("err_cnt", 64'(OpCount), 64'(exp_cnt));
            chk("err_sel", 64'(Sel), 64'(exp_sel));
            chk("err_op1", 64'(OP1), 64'(exp_op1));
            chk("err_op2", 64'(OP2), 64'(exp_op2));
            @(posedge clk); #1;
            chk("err_after_done", 64'(Done), 64'd0);
            chk("err_after_inv", 64'(Invalid), 64'd0);
            chk("err_after_ready", 64'(Ready), 64'd1);
            chk("err_after_cnt", 64'(OpCount), 64'(exp_cnt));
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(Ready), 64'd1);
        chk({tag, "_done"}, 64'(Done), 64'd0);
        chk({tag, "_inv"}, 64'(Invalid), 64'd0);
        chk({tag, "_res"}, 64'(Resultado), 64'd0);
        chk({tag, "_zf"}, 64'(ZF), 64'd0);
        chk({tag, "_cnt"}, 64'(OpCount), 64'd0);
        chk({tag, "_op1"}, 64'(OP1), 64'd0);
        chk({tag, "_op2"}, 64'(OP2), 64'd0);
        chk({tag, "_sel"}, 64'(Sel), 64'd2);
        exp_res = '0; exp_zf = 1'b0; exp_cnt = '0;
        exp_op1 = '0; exp_op2 = '0; exp_sel = 4'd2;
    endtask

    logic [5:0] legal_fn [6];

    initial begin
        legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24;
        legal_fn[3] = 6'h25; legal_fn[4] = 6'h27; legal_fn[5] = 6'h2A;
        reset = 1'b1; Start = 1'b0; ALUOp = 2'b00; Funct = 6'h00; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the plan
        run_op(2'b00, 6'h00, 32'd5, 32'd7);
        run_op(2'b01, 6'h00, 32'h1234, 32'h1234);
        run_op(2'b10, 6'h24, 32'hF0, 32'h3C);
        run_op(2'b10, 6'h25, 32'hF0, 32'h3C);
        run_op(2'b10, 6'h27, 32'hF0, 32'h3C);
        run_op(2'b10, 6'h2A, 32'hF0, 32'h3C);
        run_op(2'b10, 6'h2A, 32'd3, 32'd9);
        run_op(2'b10, 6'h20, 32'hFFFF_FFFF, 32'd1);
        run_op(2'b10, 6'h22, 32'd0, 32'd1);
        run_op(2'b10, 6'h00, 32'd11, 32'd22);
        run_op(2'b11, 6'h20, 32'd11, 32'd22);

        // Start held high: one acceptance every third edge, EXEC/DONE pulses ignored
        Start = 1'b1; ALUOp = 2'b00; A = 32'd1; B = 32'd2;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk("held_done", 64'(Done), 64'((k % 3) == 1));
            chk("held_ready", 64'(Ready), 64'((k % 3) == 2));
        end
        Start = 1'b0;
        exp_cnt = exp_cnt + 16'd4;
        exp_res = 32'd3; exp_zf = 1'b0; exp_sel = 4'd2; exp_op1 = 32'd1; exp_op2 = 32'd2;
        chk("held_cnt", 64'(OpCount), 64'(exp_cnt));
        chk("held_res", 64'(Resultado), 64'(exp_res));

        // Counter wrap, preloaded near the top to keep the run short
        dut.cnt_q = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        run_op(2'b00, 6'h00, 32'd100, 32'd200);
        run_op(2'b00, 6'h00, 32'd1, 32'd1);
        chk("wrap_zero", 64'(OpCount), 64'd0);

        // Randomized mix of legal and illegal requests
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
            else fn = legal_fn[$urandom_range(0, 5)];
            run_op(op, fn, $urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom);
        end

        // Reset mid-EXEC
        Start = 1'b1; ALUOp = 2'b00; A = 32'd40; B = 32'd2;
        @(posedge clk); #1;
        Start = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_values("midreset");
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_reset_no_done", 64'(Done), 64'd0);
            chk("post_reset_cnt", 64'(OpCount), 64'd0);
        end
        run_op(2'b10, 6'h22, 32'd50, 32'd8);
        chk("post_reset_final_cnt", 64'(OpCount), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
